// File: rtl/rotor_bank.sv
// rotor_bank: chain of NUM_ROT substitution rotors with odometer (notch)
// stepping, runtime-loadable wiring and valid/ready handshakes.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   dec                     0 = encode, 1 = decode (sampled on acceptance)
//   in_valid/in_ready/in_data    input symbol handshake
//   out_valid/out_ready/out_data/out_err  result handshake; out_err flags a
//                           decode lookup that found no wiring match
//   cfg_we/cfg_mode/cfg_sel/cfg_addr/cfg_data  configuration write port
//                           (mode 0 wiring, 1 position, 2 notch, 3 step)
//   pos_out                 current rotor positions, rotor 0 in the LSBs
//
// Optional feature macro: ROTOR_BANK_REFLECTOR_EN adds a reflector table
// (cfg_sel = NUM_ROT, mode 0); the path becomes forward, reflect, inverse
// and dec is ignored.
module rotor_bank #(
  parameter int ALPHA   = 26,
  parameter int SYM_W   = 8,
  parameter int BASE    = 65,
  parameter int NUM_ROT = 3,
  parameter int POS_W   = $clog2(ALPHA)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dec,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SYM_W-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SYM_W-1:0]         out_data,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_mode,
  input  logic [2:0]               cfg_sel,
  input  logic [POS_W-1:0]         cfg_addr,
  input  logic [SYM_W-1:0]         cfg_data,
  output logic [NUM_ROT*POS_W-1:0] pos_out
);

`ifdef ROTOR_BANK_REFLECTOR_EN
  localparam int RUN_LEN = 2 * NUM_ROT + 1;
`else
  localparam int RUN_LEN = NUM_ROT;
`endif
  localparam int CNT_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_RUN, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic                   r_live;
  logic [POS_W-1:0]       r_s;
  logic [SYM_W-1:0]       r_raw;
  logic                   r_oor, r_dec, r_err, r_out_valid;
  logic [SYM_W-1:0]       r_out_data;
  logic [CNT_W-1:0]       r_cnt;
  logic [POS_W-1:0]       r_pos   [NUM_ROT];
  logic [POS_W-1:0]       r_step  [NUM_ROT];
  logic [POS_W-1:0]       r_notch [NUM_ROT];
  logic [SYM_W-1:0]       r_wire  [NUM_ROT][ALPHA];
`ifdef ROTOR_BANK_REFLECTOR_EN
  logic [SYM_W-1:0]       r_refl  [ALPHA];
`endif

  logic                   w_accept, w_in_ok, w_val_ok, w_addr_ok, w_sel_ok;
  logic [SYM_W-1:0]       w_off, w_tgt;
  logic [POS_W-1:0]       w_cfg_val, w_p, w_sp, w_j, w_s_next, w_ref_s;
  logic [3:0]             w_k;
  logic                   w_inv, w_use_refl, w_hit, w_err_now;
  logic [SYM_W-1:0]       w_row [ALPHA];
  logic [NUM_ROT-1:0]     w_carry;

  // (a + b) mod ALPHA for operands already below ALPHA
  function automatic logic [POS_W-1:0] add_mod(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    logic [POS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (POS_W+1)'(ALPHA)) sum = sum - (POS_W+1)'(ALPHA);
    else                          sum = sum;
    return sum[POS_W-1:0];
  endfunction

  // (a - b) mod ALPHA for operands already below ALPHA
  function automatic logic [POS_W-1:0] sub_mod(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    logic [POS_W:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + (POS_W+1)'(ALPHA) - {1'b0, b};
    return d[POS_W-1:0];
  endfunction

  // (w - BASE - p) mod ALPHA; wiring entries may hold any code, so a true mod
  function automatic logic [POS_W-1:0] wire_to_idx(input logic [SYM_W-1:0] w,
                                                    input logic [POS_W-1:0] p);
    int t;
    t = int'(w) - BASE - int'(p);
    t = t % ALPHA;
    if (t < 0) t = t + ALPHA;
    else       t = t;
    return POS_W'(t);
  endfunction

  assign w_accept  = in_valid & in_ready;
  assign w_off     = in_data - SYM_W'(BASE);
  assign w_in_ok   = (w_off < SYM_W'(ALPHA));
  assign w_cfg_val = cfg_data[POS_W-1:0];
  assign w_val_ok  = ({1'b0, w_cfg_val} < (POS_W+1)'(ALPHA));
  assign w_addr_ok = ({1'b0, cfg_addr} < (POS_W+1)'(ALPHA));
  assign w_sel_ok  = ({1'b0, cfg_sel} < 4'(NUM_ROT));

  assign in_ready  = r_live & (r_state == S_IDLE) & ~cfg_we;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_err;

  // Pack positions for observation, rotor 0 in the LSBs
  always_comb begin
    pos_out = '0;
    for (int r = 0; r < NUM_ROT; r++) pos_out[r*POS_W +: POS_W] = r_pos[r];
  end

  // Odometer carries: rotor k moves when rotor k-1 sits on its notch
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int k = 1; k < NUM_ROT; k++) w_carry[k] = (r_pos[k-1] == r_notch[k-1]);
  end

  // Which rotor (or the reflector) this RUN cycle visits, and in which direction
  always_comb begin
    w_k        = '0;
    w_inv      = 1'b0;
    w_use_refl = 1'b0;
`ifdef ROTOR_BANK_REFLECTOR_EN
    if (4'(r_cnt) < 4'(NUM_ROT)) begin
      w_k = 4'(r_cnt);
    end else if (4'(r_cnt) == 4'(NUM_ROT)) begin
      w_use_refl = 1'b1;
    end else begin
      w_k   = 4'(2 * NUM_ROT) - 4'(r_cnt);
      w_inv = 1'b1;
    end
`else
    if (r_dec) begin
      w_k   = 4'(NUM_ROT - 1) - 4'(r_cnt);
      w_inv = 1'b1;
    end else begin
      w_k = 4'(r_cnt);
    end
`endif
  end

  // Select the visited rotor's position and wiring row
  always_comb begin
    w_p   = r_pos[0];
    w_row = r_wire[0];
    for (int r = 0; r < NUM_ROT; r++) begin
      if (w_k == 4'(r)) begin
        w_p   = r_pos[r];
        w_row = r_wire[r];
      end else begin
        w_p = w_p;
      end
    end
  end

  assign w_sp  = add_mod(r_s, w_p);
  assign w_tgt = SYM_W'(BASE) + SYM_W'(w_sp);

  // Inverse lookup: scan high to low so the lowest matching entry wins
  always_comb begin
    w_hit = 1'b0;
    w_j   = '0;
    for (int j = ALPHA - 1; j >= 0; j--) begin
      if (w_row[j] == w_tgt) begin
        w_hit = 1'b1;
        w_j   = POS_W'(j);
      end else begin
        w_hit = w_hit;
      end
    end
  end

`ifdef ROTOR_BANK_REFLECTOR_EN
  assign w_ref_s = wire_to_idx(r_refl[r_s], '0);
`else
  assign w_ref_s = '0;
`endif

  // One rotor stage of symbol arithmetic
  always_comb begin
    w_s_next  = '0;
    w_err_now = 1'b0;
    if (w_use_refl) begin
      w_s_next = w_ref_s;
    end else if (w_inv) begin
      if (w_hit) begin
        w_s_next = sub_mod(w_j, w_p);
      end else begin
        w_s_next  = '0;
        w_err_now = 1'b1;
      end
    end else begin
      w_s_next = wire_to_idx(w_row[w_sp], w_p);
    end
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_STEP; else w_next = S_IDLE;
      S_STEP: w_next = S_RUN;
      S_RUN:  if (r_cnt == CNT_W'(RUN_LEN - 1)) w_next = S_DONE; else w_next = S_RUN;
      S_DONE: if (out_ready) w_next = S_IDLE; else w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Symbol datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live      <= 1'b0;
      r_s         <= '0;
      r_raw       <= '0;
      r_oor       <= 1'b0;
      r_dec       <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_raw <= in_data;
            r_oor <= ~w_in_ok;
            r_s   <= w_off[POS_W-1:0];
            r_dec <= dec;
            r_err <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_STEP: r_cnt <= '0;
        S_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!r_oor) begin
            r_s   <= w_s_next;
            r_err <= r_err | w_err_now;
          end
          if (r_cnt == CNT_W'(RUN_LEN - 1)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_oor ? r_raw : (SYM_W'(BASE) + SYM_W'(w_s_next));
          end
        end
        S_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  // Rotor state: configuration writes in IDLE, odometer stepping in STEP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_ROT; r++) begin
        r_pos[r]   <= '0;
        r_step[r]  <= POS_W'(1);
        r_notch[r] <= POS_W'(ALPHA - 1);
        for (int i = 0; i < ALPHA; i++) r_wire[r][i] <= SYM_W'(BASE + i);
      end
`ifdef ROTOR_BANK_REFLECTOR_EN
      for (int i = 0; i < ALPHA; i++) r_refl[i] <= SYM_W'(BASE + ALPHA - 1 - i);
`endif
    end else if ((r_state == S_IDLE) && cfg_we) begin
`ifdef ROTOR_BANK_REFLECTOR_EN
      if ((cfg_mode == 2'd0) && w_addr_ok && ({1'b0, cfg_sel} == 4'(NUM_ROT)))
        r_refl[cfg_addr] <= cfg_data;
`endif
      for (int r = 0; r < NUM_ROT; r++) begin
        if (w_sel_ok && (cfg_sel == 3'(r))) begin
          case (cfg_mode)
            2'd0: if (w_addr_ok) r_wire[r][cfg_addr] <= cfg_data;
            2'd1: if (w_val_ok)  r_pos[r]   <= w_cfg_val;
            2'd2: if (w_val_ok)  r_notch[r] <= w_cfg_val;
            2'd3: if (w_val_ok)  r_step[r]  <= w_cfg_val;
            default: r_pos[r] <= r_pos[r];
          endcase
        end
      end
    end else if ((r_state == S_STEP) && !r_oor) begin
      for (int k = 0; k < NUM_ROT; k++)
        if (w_carry[k]) r_pos[k] <= add_mod(r_pos[k], r_step[k]);
    end
  end

endmodule

// File: tb/tb_rotor_bank.sv
module tb_rotor_bank;
  localparam int ALPHA = 26;
  localparam int BASE  = 65;
  localparam int NR    = 2;
  localparam int PW    = 5;

  logic       clk = 1'b0, reset_n = 1'b0, dec = 1'b0, in_valid = 1'b0;
  logic       out_ready = 1'b0, cfg_we = 1'b0;
  logic       in_ready, out_valid, out_err;
  logic [7:0] in_data = 8'd0, cfg_data = 8'd0, out_data;
  logic [1:0] cfg_mode = 2'd0;
  logic [2:0] cfg_sel = 3'd0;
  logic [4:0] cfg_addr = 5'd0;
  logic [9:0] pos_out;

  rotor_bank #(.ALPHA(ALPHA), .SYM_W(8), .BASE(BASE), .NUM_ROT(NR)) dut (
    .clk(clk), .reset_n(reset_n), .dec(dec), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pos_out(pos_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [9:0] pos;
  } exp_t;
  exp_t exp_q[$];

  int m_wire [NR][ALPHA];
  int m_pos [NR];
  int m_step [NR];
  int m_notch [NR];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int md(input int x);
    int r;
    r = x % ALPHA;
    if (r < 0) r = r + ALPHA;
    return r;
  endfunction

  function automatic logic [9:0] pos_vec();
    logic [9:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v = v | (10'(m_pos[r]) << (r * PW));
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_pos[r] = 0; m_step[r] = 1; m_notch[r] = ALPHA - 1;
      for (int i = 0; i < ALPHA; i++) m_wire[r][i] = BASE + i;
    end
  endtask

  // Reference behaviour for one accepted symbol; result goes to the scoreboard
  task automatic model_push(input logic [7:0] sym, input logic d);
    exp_t e;
    int s, p, t, hit;
    int old [NR];
    e.err = 1'b0;
    s = int'(sym) - BASE;
    if (s < 0 || s >= ALPHA) begin
      e.data = sym;
    end else begin
      old = m_pos;
      for (int k = 0; k < NR; k++) begin
        if (k == 0 || old[k-1] == m_notch[k-1]) begin
          m_pos[k] = m_pos[k] + m_step[k];
          if (m_pos[k] >= ALPHA) m_pos[k] = m_pos[k] - ALPHA;
        end
      end
      if (!d) begin
        for (int k = 0; k < NR; k++) begin
          p = m_pos[k];
          s = md(m_wire[k][(s + p) % ALPHA] - BASE - p);
        end
      end else begin
        for (int k = NR - 1; k >= 0; k--) begin
          p = m_pos[k];
          t = (s + p) % ALPHA;
          hit = -1;
          for (int j = 0; j < ALPHA; j++)
            if (hit < 0 && m_wire[k][j] - BASE == t) hit = j;
          if (hit < 0) begin s = 0; e.err = 1'b1; end
          else s = md(hit - p);
        end
      end
      e.data = 8'(BASE + s);
    end
    e.pos = pos_vec();
    exp_q.push_back(e);
  endtask

  task automatic cfg_write(input int mode, input int sel, input int addr, input int data);
    int v;
    @(negedge clk);
    cfg_we = 1'b1; cfg_mode = 2'(mode); cfg_sel = 3'(sel);
    cfg_addr = 5'(addr); cfg_data = 8'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    v = data % 32;
    if (sel < NR) begin
      case (mode)
        0: if (addr < ALPHA) m_wire[sel][addr] = data;
        1: if (v < ALPHA) m_pos[sel] = v;
        2: if (v < ALPHA) m_notch[sel] = v;
        3: if (v < ALPHA) m_step[sel] = v;
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_out_err", out_err, 1'b0);
    check_eq("rst_pos", pos_out, 10'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rdy_before_clk", in_ready, 1'b0);
    @(posedge clk); #1;
    check_eq("rdy_after_rst", in_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] sym, input logic d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = sym; dec = d;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("in_ready_wait", in_ready, 1'b1);
    if (in_ready) begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      model_push(sym, d);
    end
    in_valid = 1'b0;
  endtask

  // Wait for a result, score it, optionally hold it under backpressure
  task automatic collect(input int hold, input logic cfg_in_done, output logic [7:0] got);
    exp_t e;
    int n;
    n = 0;
    e.data = 8'd0; e.err = 1'b0; e.pos = 10'd0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check_eq("out_valid_seen", out_valid, 1'b1);
    check_eq("latency", cyc - acc_cyc, NR + 1);
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("out_data", out_data, e.data);
      check_eq("out_err", out_err, e.err);
      check_eq("pos_out", pos_out, e.pos);
    end
    for (int i = 0; i < hold; i++) begin
      if (cfg_in_done && i == 1) begin
        cfg_we = 1'b1; cfg_mode = 2'd1; cfg_sel = 3'd0; cfg_data = 8'd7;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      check_eq("hold_data", out_data, e.data);
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_in_ready", in_ready, 1'b0);
    end
    cfg_we = 1'b0;
    got = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("valid_clear", out_valid, 1'b0);
  endtask

  task automatic load_enigma();
    string w;
    w = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    for (int i = 0; i < ALPHA; i++) cfg_write(0, 0, i, int'(w[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;
    logic [7:0] ct [5];
    string hello;
    hello = "HELLO";

    do_reset();

    // Encode 'A' through the Enigma rotor I wiring
    load_enigma();
    send(8'h41, 1'b0);
    collect(0, 1'b0, g);
    check_eq("enc_A_is_J", g, 8'h4A);
    check_eq("pos_after_A", pos_out, 10'd1);

    // Decode 'J' with the same start state
    do_reset();
    load_enigma();
    send(8'h4A, 1'b1);
    collect(0, 1'b0, g);
    check_eq("dec_J_is_A", g, 8'h41);

    // HELLO round trip from position 0
    cfg_write(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(hello[i], 1'b0);
      collect(0, 1'b0, ct[i]);
    end
    cfg_write(1, 0, 0, 0);
    cfg_write(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(ct[i], 1'b1);
      collect(0, 1'b0, g);
      check_eq("hello_roundtrip", g, hello[i]);
    end

    // Out-of-range symbol passes through, positions untouched
    send(8'h35, 1'b0);
    collect(0, 1'b0, g);
    check_eq("pass_data", g, 8'h35);
    check_eq("pass_err", out_err, 1'b0);

    // Dropped writes: value >= ALPHA, rotor index >= NUM_ROT
    cfg_write(1, 0, 0, 30);
    cfg_write(1, 5, 0, 3);
    cfg_write(2, 2, 0, 4);
    check_eq("drop_writes", pos_out, pos_vec());
    cfg_write(3, 0, 0, 2);

    // Backpressure with an ignored position write during DONE
    send(8'h43, 1'b0);
    collect(5, 1'b1, g);
    check_eq("pos_after_done_cfg", pos_out, pos_vec());
    send(8'h44, 1'b0);
    collect(0, 1'b0, g);

    // Odometer carry from rotor 0 notch
    do_reset();
    cfg_write(1, 0, 0, 16);
    cfg_write(2, 0, 0, 16);
    cfg_write(1, 1, 0, 0);
    send(8'h41, 1'b0);
    collect(0, 1'b0, g);
    check_eq("odo_first", pos_out, {5'd1, 5'd17});
    send(8'h42, 1'b0);
    collect(0, 1'b0, g);
    check_eq("odo_second", pos_out, {5'd1, 5'd18});

    // Reset asserted during RUN
    load_enigma();
    send(8'h41, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_pos", pos_out, 10'd0);
    check_eq("midrst_ready", in_ready, 1'b0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midrst_no_ghost", out_valid, 1'b0);
    send(8'h41, 1'b0);
    collect(0, 1'b0, g);
    check_eq("midrst_identity", g, 8'h41);

    // Decode with every wiring entry 'A': no inverse match
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < ALPHA; i++) cfg_write(0, r, i, 65);
    send(8'h42, 1'b1);
    collect(0, 1'b0, g);
    check_eq("err_flag", out_err, 1'b1);
    check_eq("err_data", g, 8'h41);
    send(8'h42, 1'b0);
    collect(0, 1'b0, g);
    check_eq("err_cleared", out_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
